spi_sclk_engine: RTL
====================

// Module: spi_sclk_engine
// PURPOSE
//  Parametrised successor to the SPI serial-clock generator. Runs a full transfer from one go pulse:
//  chip-select setup, 2*len SCLK edges in any CPOL/CPHA mode, then chip-select hold.
//  Emits one-cycle shift/sample strobes for the shift register and a done pulse to the control FSM.
//  Sits between the Wishbone control registers and the SPI shift register.
// PARAMETERS
//  DIV_LEN  16  width of divider; SCLK half-period = divider+1 wb_clk_in cycles
//  CNT_LEN   7  width of len; len=0 encodes 2**CNT_LEN bits
//  GAP_LEN   8  width of cs_setup / cs_hold counts (wb_clk_in cycles)
// PORTS
//  wb_clk_in    in   1        system clock; all logic on rising edge
//  wb_rst       in   1        synchronous reset, active-high
//  go           in   1        start request; accepted only in IDLE
//  abort        in   1        cancel transfer; honoured only outside IDLE
//  divider      in   DIV_LEN  half-period minus one; latched at go
//  cpol         in   1        SCLK idle level; latched at go
//  cpha         in   1        0: sample leading/shift trailing; 1: shift leading/sample trailing; latched at go
//  len          in   CNT_LEN  bits per transfer; latched at go
//  cs_setup     in   GAP_LEN  cycles from cs_active rise to RUN entry; latched at go
//  cs_hold      in   GAP_LEN  cycles in HOLD before release; latched at go
//  sclk_out     out  1        serial clock (registered)
//  shift_pulse  out  1        one-cycle strobe: drive next MOSI bit
//  sample_pulse out  1        one-cycle strobe: capture MISO
//  last_clk     out  1        next SCLK edge is the final edge of the transfer
//  tip          out  1        transfer in progress (any state except IDLE)
//  cs_active    out  1        chip-select request, active-high
//  done         out  1        one-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE; sclk_out, shift_pulse, sample_pulse, last_clk, tip, cs_active, done all 0; latched cpol=0.
//  FSM: IDLE -> SETUP (cs_setup!=0) or RUN (cs_setup==0) -> RUN -> HOLD -> IDLE.
//  IDLE: sclk_out = live cpol registered (1-cycle lag). go=1 at cycle T latches config.
//    At T+1: tip=1, cs_active=1. SETUP lasts cs_setup cycles; R is the first RUN cycle.
//  RUN: edge k (k=1..2N, N=len or 2**CNT_LEN) is visible at R + k*(divider+1).
//    divider=0 gives SCLK = wb_clk_in/2.
//    Odd k is the leading edge (away from cpol); even k is the trailing edge.
//  Strobes are asserted in the same cycle the new sclk_out level first appears.
//    cpha=0: sample_pulse on odd k; shift_pulse on even k except k=2N (N samples, N-1 shifts).
//    cpha=1: shift_pulse on odd k; sample_pulse on even k (N of each).
//    The first bit for cpha=0 is driven by the shift register at go; no strobe is issued for it.
//  last_clk: 1 from the cycle of edge 2N-1 through the cycle before edge 2N; 0 otherwise.
//  After edge 2N, sclk_out stays at cpol for one more half-period; HOLD is entered at E2N + divider + 1.
//  HOLD: lasts cs_hold cycles (0 = none). The next cycle is IDLE with done=1, cs_active=0, tip=0.
//  abort in SETUP/RUN/HOLD: next cycle is IDLE with cs_active=0, tip=0, sclk_out=latched cpol.
//    No done, no strobes. abort in IDLE is ignored.
//  go outside IDLE is ignored. go and abort together in IDLE: go is accepted.
//  Input changes during a transfer have no effect (config is latched at go).
//  Counters: divider count down-counts modulo divider+1; edge counter is CNT_LEN+1 bits (no wrap at 2**CNT_LEN bits).
//  wb_rst mid-transfer: all outputs take reset values on the next clock edge; no done.
// TESTING
//  1. divider=1, cpol=0, cpha=0, len=8, setup=hold=0, go@T -> edges @T+3, T+5, ..., T+33.
//     8 sample_pulse on rising edges, 7 shift_pulse, done @T+35.
//  2. divider=0, cpol=1, cpha=1, len=4 -> SCLK idles high, 8 edges one cycle apart.
//     4 shift_pulse on falling edges, 4 sample_pulse on rising edges, sclk_out=1 after.
//  3. divider=2, cs_setup=3, cs_hold=2, len=1 -> cs_active@T+1, edges @T+7, T+10.
//     HOLD @T+13..T+14, done and cs_active=0 @T+15.
//  4. CNT_LEN=3 (override), len=0 -> 16 edges and 8 sample_pulse.
//     last_clk high only between edge 15 and edge 16.
//  5. abort one cycle after edge 3 -> next cycle tip=0, cs_active=0, sclk_out=cpol, done never asserted.
//     go pulses during the transfer are ignored; a fresh go then completes normally.
//  6. wb_rst asserted mid-RUN -> every output 0 on the next edge, FSM in IDLE.
//     Subsequent go behaves as in test 1.

Source files
------------

// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SPI serial-clock engine: CS setup, 2*len SCLK edges in any mode, CS hold
// Config is captured at go; strobes and SCLK are registered so they appear together.
module spi_sclk_engine #(
    parameter int DIV_LEN = 16,
    parameter int CNT_LEN = 7,
    parameter int GAP_LEN = 8
) (
    input  logic               wb_clk_in,
    input  logic               wb_rst,
    input  logic               go,
    input  logic               abort,
    input  logic [DIV_LEN-1:0] divider,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [CNT_LEN-1:0] len,
    input  logic [GAP_LEN-1:0] cs_setup,
    input  logic [GAP_LEN-1:0] cs_hold,
    output logic               sclk_out,
    output logic               shift_pulse,
    output logic               sample_pulse,
    output logic               last_clk,
    output logic               tip,
    output logic               cs_active,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [DIV_LEN-1:0] DIV_ONE  = {{(DIV_LEN-1){1'b0}}, 1'b1};
    localparam logic [GAP_LEN-1:0] GAP_ONE  = {{(GAP_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_LEN-1:0] LEN_ONE  = {{(CNT_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_LEN:0]   EDGE_ONE = {{CNT_LEN{1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [DIV_LEN-1:0] div_cnt_q, div_cnt_d;
    logic [GAP_LEN-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_LEN:0]   edge_cnt_q, edge_cnt_d;
    logic               tail_q, tail_d;

    logic [DIV_LEN-1:0] divider_q, divider_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [CNT_LEN-1:0] len_q, len_d;
    logic [GAP_LEN-1:0] hold_q, hold_d;

    logic               sclk_q, sclk_d;
    logic               shift_q, shift_d;
    logic               sample_q, sample_d;
    logic               last_q, last_d;
    logic               tip_q, tip_d;
    logic               cs_q, cs_d;
    logic               done_q, done_d;

    // len-1 wraps for len=0, so {len-1,1} is 2N-1 edges-done index of the final edge
    logic [CNT_LEN-1:0] len_m1;
    logic [CNT_LEN:0]   last_idx;
    logic [CNT_LEN:0]   penult_idx;
    logic               odd_edge;

    always_comb begin
        len_m1     = len_q - LEN_ONE;
        last_idx   = {len_m1, 1'b1};
        penult_idx = {len_m1, 1'b0};
        odd_edge   = ~edge_cnt_q[0];
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tail_d     = tail_q;
        divider_d  = divider_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        len_d      = len_q;
        hold_d     = hold_q;
        sclk_d     = sclk_q;
        shift_d    = 1'b0;
        sample_d   = 1'b0;
        last_d     = last_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                last_d = 1'b0;
                if (go) begin
                    divider_d  = divider;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    len_d      = len;
                    hold_d     = cs_hold;
                    edge_cnt_d = '0;
                    tail_d     = 1'b0;
                    div_cnt_d  = divider;
                    if (cs_setup != '0) begin
                        state_d   = S_SETUP;
                        gap_cnt_d = cs_setup - GAP_ONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sclk_d  = cpol_q;
                end else if (gap_cnt_q == '0) begin
                    state_d   = S_RUN;
                    div_cnt_d = divider_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sclk_d  = cpol_q;
                    last_d  = 1'b0;
                end else if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end else begin
                    div_cnt_d = divider_q;
                    if (tail_q) begin
                        // trailing idle half-period after the last edge has elapsed
                        if (hold_q != '0) begin
                            state_d   = S_HOLD;
                            gap_cnt_d = hold_q - GAP_ONE;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sclk_d = ~sclk_q;
                        last_d = (edge_cnt_q == penult_idx);
                        if (cpha_q) begin
                            shift_d  = odd_edge;
                            sample_d = ~odd_edge;
                        end else begin
                            sample_d = odd_edge;
                            shift_d  = ~odd_edge && (edge_cnt_q != last_idx);
                        end
                        if (edge_cnt_q == last_idx) begin
                            tail_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + EDGE_ONE;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sclk_d  = cpol_q;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        tip_d = (state_d != S_IDLE);
        cs_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_in) begin
        if (wb_rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tail_q     <= 1'b0;
            divider_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            len_q      <= '0;
            hold_q     <= '0;
            sclk_q     <= 1'b0;
            shift_q    <= 1'b0;
            sample_q   <= 1'b0;
            last_q     <= 1'b0;
            tip_q      <= 1'b0;
            cs_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tail_q     <= tail_d;
            divider_q  <= divider_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            sclk_q     <= sclk_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            last_q     <= last_d;
            tip_q      <= tip_d;
            cs_q       <= cs_d;
            done_q     <= done_d;
        end
    end

    assign sclk_out     = sclk_q;
    assign shift_pulse  = shift_q;
    assign sample_pulse = sample_q;
    assign last_clk     = last_q;
    assign tip          = tip_q;
    assign cs_active    = cs_q;
    assign done         = done_q;

endmodule
